// File: rtl/seq_detect_pkg.sv
// Shared state encoding, parameter defaults and pattern-length clamp for the
// serial pattern detector.
package seq_detect_pkg;

  localparam int PAT_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT = 8;

  // Longest supported pattern; out-of-range lengths fall back to this.
  localparam logic [3:0] LEN_MAX = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } ctrlState;

  // A length of zero or beyond LEN_MAX makes no sense, so treat it as LEN_MAX.
  function automatic logic [3:0] clampLen(input logic [3:0] len);
    if ((len == 4'd0) || (len > LEN_MAX)) begin
      return LEN_MAX;
    end
    return len;
  endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-level match engine: keeps the recent bit history and a fill count of how
// many of those bits are still eligible, and flags a hit when the newest len
// bits equal the pattern.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             bit_i,
  input  logic             bit_en_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [3:0]       len_i,
  input  logic             overlap_i,
  output logic             hit_o
);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [PAT_W-1:0] histShifted;
  logic [PAT_W-1:0] lenMask;
  logic [3:0]       fillInc;
  logic             hitNow;

  assign histShifted = {hist_q[PAT_W-2:0], bit_i};
  assign fillInc     = (fill_q >= len_i) ? len_i : (fill_q + 4'd1);

  // Build a mask covering the low len bits so only the active pattern is compared.
  always_comb begin
    lenMask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      lenMask[i] = (i < int'(len_i));
    end
  end

  // The incoming bit counts toward fill, so a hit needs the incremented fill to reach len.
  assign hitNow = bit_en_i && (fillInc == len_i) &&
                  (((histShifted ^ pattern_i) & lenMask) == '0);
  assign hit_o  = hitNow;

  // Shift history and update fill; non-overlap hits consume their bits by zeroing fill.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en_i) begin
      hist_d = histShifted;
      if (hitNow && !overlap_i) begin
        fill_d = '0;
      end else begin
        fill_d = fillInc;
      end
    end
  end

  // History and fill registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Pattern detector controller: accepts bytes over a valid/ready handshake,
// serializes them MSB first into the match core, and keeps a saturating match
// counter with a sticky threshold interrupt.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [3:0]       cfg_len,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_thresh,
  input  logic             start,
  input  logic             stop,
  input  logic             s_valid,
  input  logic [PAT_W-1:0] s_data,
  output logic             s_ready,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             irq,
  input  logic             irq_clr
);

  localparam int BC_W = $clog2(PAT_W + 1);

  ctrlState         state_q, state_d;
  logic [PAT_W-1:0] shiftReg_q, shiftReg_d;
  logic [BC_W-1:0]  bitCnt_q, bitCnt_d;
  logic             stopPend_q, stopPend_d;

  logic [PAT_W-1:0] cfgPattern_q, cfgPattern_d;
  logic [3:0]       cfgLen_q, cfgLen_d;
  logic             cfgOverlap_q, cfgOverlap_d;
  logic [CNT_W-1:0] cfgThresh_q, cfgThresh_d;

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] countInc;
  logic             irq_q, irq_d;
  logic             match_q, match_d;

  logic             coreClear;
  logic             coreBitEn;
  logic             coreHit;
  logic             irqSet;

  // Stop wins over a same-cycle accept, so ready is withdrawn while stop is high.
  assign s_ready     = (state_q == ARMED) && !stop;
  assign busy        = (state_q != IDLE);
  assign match       = match_q;
  assign match_count = count_q;
  assign irq         = irq_q;

  // Controller FSM and serializer: one byte per accept, PAT_W bit-cycles in SHIFT.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    bitCnt_d   = bitCnt_q;
    stopPend_d = stopPend_q;
    coreClear  = 1'b0;
    coreBitEn  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ARMED;
          coreClear  = 1'b1;
          stopPend_d = 1'b0;
        end
      end
      ARMED: begin
        if (stop) begin
          state_d = IDLE;
        end else if (s_valid) begin
          state_d    = SHIFT;
          shiftReg_d = s_data;
          bitCnt_d   = '0;
          stopPend_d = 1'b0;
        end
      end
      SHIFT: begin
        coreBitEn  = 1'b1;
        shiftReg_d = {shiftReg_q[PAT_W-2:0], 1'b0};
        bitCnt_d   = bitCnt_q + BC_W'(1);
        if (stop) begin
          stopPend_d = 1'b1;
        end
        if (bitCnt_q == BC_W'(PAT_W - 1)) begin
          bitCnt_d   = '0;
          stopPend_d = 1'b0;
          state_d    = (stopPend_q || stop) ? IDLE : ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Configuration is only writable while idle so a running search never changes underfoot.
  always_comb begin
    cfgPattern_d = cfgPattern_q;
    cfgLen_d     = cfgLen_q;
    cfgOverlap_d = cfgOverlap_q;
    cfgThresh_d  = cfgThresh_q;
    if ((state_q == IDLE) && cfg_we) begin
      cfgPattern_d = cfg_pattern;
      cfgLen_d     = clampLen(cfg_len);
      cfgOverlap_d = cfg_overlap;
      cfgThresh_d  = cfg_thresh;
    end
  end

  // Saturating match counter and sticky irq; a new threshold crossing beats irq_clr.
  always_comb begin
    count_d  = count_q;
    irq_d    = irq_q;
    match_d  = coreHit;
    countInc = count_q + CNT_W'(1);
    irqSet   = coreHit && (count_q != {CNT_W{1'b1}}) &&
               (countInc == cfgThresh_q) && (cfgThresh_q != '0);
    if (coreClear) begin
      count_d = '0;
      irq_d   = 1'b0;
    end else begin
      if (coreHit && (count_q != {CNT_W{1'b1}})) begin
        count_d = countInc;
      end
      if (irqSet) begin
        irq_d = 1'b1;
      end else if (irq_clr) begin
        irq_d = 1'b0;
      end
    end
  end

  // All controller state registers; reset abandons any byte in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      shiftReg_q   <= '0;
      bitCnt_q     <= '0;
      stopPend_q   <= 1'b0;
      cfgPattern_q <= '0;
      cfgLen_q     <= LEN_MAX;
      cfgOverlap_q <= 1'b0;
      cfgThresh_q  <= '0;
      count_q      <= '0;
      irq_q        <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shiftReg_q   <= shiftReg_d;
      bitCnt_q     <= bitCnt_d;
      stopPend_q   <= stopPend_d;
      cfgPattern_q <= cfgPattern_d;
      cfgLen_q     <= cfgLen_d;
      cfgOverlap_q <= cfgOverlap_d;
      cfgThresh_q  <= cfgThresh_d;
      count_q      <= count_d;
      irq_q        <= irq_d;
      match_q      <= match_d;
    end
  end

  seq_match_core #(
    .PAT_W(PAT_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (coreClear),
    .bit_i    (shiftReg_q[PAT_W-1]),
    .bit_en_i (coreBitEn),
    .pattern_i(cfgPattern_q),
    .len_i    (cfgLen_q),
    .overlap_i(cfgOverlap_q),
    .hit_o    (coreHit)
  );

endmodule
